pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Front-end fetch stage for the single-issue MIPS-style datapath; sits upstream of decode/ALU.
//  Holds the PC and issues req/ack reads to instruction memory.
//  Presents one fetched instruction to decode through a valid/ready 1-entry output buffer.
//  Consumes the ALU's branch/jump resolution (Branch/Jump flags, O_out as JR target) to redirect fetch.
//  No branch delay slot: a redirect discards any wrong-path fetch.
// PARAMETERS
//  RESET_PC   32'h0000_0000   PC fetched first after reset; bits [1:0] must be 0
// PORTS
//  Clk_in            in   1   clock, all state updates on rising edge
//  Reset_n_in        in   1   synchronous active-low reset
//  ExValid_in        in   1   EX-stage instruction valid; qualifies Branch_in/Jump_in
//  Branch_in         in   1   ALU Branch_out: conditional branch taken
//  Jump_in           in   1   ALU Jump_out: J/JR taken
//  JumpTarget_in     in   32  jump target (ALU O_out for JR, pre-formed for J)
//  BranchPc_in       in   32  PC of the branch instruction in EX
//  BranchOffset_in   in   32  sign-extended 16-bit branch immediate (word offset)
//  ImemReq_out       out  1   instruction memory read request
//  ImemAddr_out      out  32  read address, stable while ImemReq_out=1
//  ImemAck_in        in   1   read complete; ImemData_in valid this cycle
//  ImemData_in       in   32  instruction word
//  Instr_out         out  32  fetched instruction to decode
//  InstrPc_out       out  32  PC of Instr_out
//  InstrValid_out    out  1   Instr_out/InstrPc_out valid
//  InstrReady_in     in   1   decode accepts; transfer when Valid & Ready
//  AddrErr_out       out  1   1-cycle pulse: redirect target had bits[1:0]!=0
// BEHAVIOUR
//  Reset (Reset_n_in=0 at edge, overrides all):
//   state=IDLE; pc=RESET_PC; discard=0; ImemReq_out=0; ImemAddr_out=RESET_PC;
//   Instr_out=0; InstrPc_out=0; InstrValid_out=0; AddrErr_out=0. Mid-operation reset drops in-flight data.
//  All outputs registered. States: IDLE, REQ, HOLD.
//   IDLE: next cycle -> REQ, ImemReq_out=1, ImemAddr_out=pc.
//   REQ: ImemReq_out held 1, ImemAddr_out frozen until ImemAck_in.
//    On ack with discard=0 and no redirect: Instr_out=ImemData_in, InstrPc_out=ImemAddr_out,
//     InstrValid_out=1, pc=ImemAddr_out+4 -> HOLD, ImemReq_out=0.
//    Ack same cycle as request issue is legal; minimum ack-to-valid latency 1 cycle.
//   HOLD: hold outputs while InstrReady_in=0.
//    On Valid&Ready: InstrValid_out=0 -> REQ, ImemReq_out=1, ImemAddr_out=pc.
//    Throughput: one instruction per 2 cycles at zero memory wait.
//  Redirect = ExValid_in & (Branch_in | Jump_in).
//   Target: Jump_in ? JumpTarget_in : BranchPc_in+4+(BranchOffset_in<<2).
//   Jump wins if both are set; all arithmetic is mod 2^32.
//   If target[1:0]!=0: force bits [1:0]=00 and pulse AddrErr_out next cycle.
//   HOLD: pc=target; InstrValid_out=0 next cycle -> REQ at target.
//    Applies even if Ready is asserted same cycle; the handshake completes but pc still redirects.
//   REQ, no ack: pc=target, discard=1; ImemAddr_out unchanged.
//    On later ack: data dropped, discard=0, ImemAddr_out=pc next cycle, ImemReq_out stays 1.
//   REQ, ack same cycle: data dropped, ImemAddr_out=target next cycle, ImemReq_out stays 1.
//   IDLE: pc=target.
//   Repeated redirects while discard=1: latest target wins.
//  Sequential wrap: pc 32'hFFFF_FFFC +4 -> 32'h0000_0000, no flag.
// TESTING
//  Reset, 1-cycle-ack memory, Ready=1 -> addrs 0,4,8 fetched; InstrPc_out=0,4,8; Valid every 2nd cycle.
//  Ready=0 for 5 cycles in HOLD -> Instr_out/InstrPc_out stable; no ImemReq_out; resumes at pc+4.
//  Branch_in=1, BranchPc=0x100, Offset=-2 (0xFFFFFFFE) -> next fetch addr 0xFC.
//  Jump_in=1, JumpTarget=0x2000 during a 3-cycle ack wait at 0x40:
//   0x40 data dropped; next ImemAddr_out=0x2000; no Valid for 0x40.
//  JumpTarget=0x2002 -> AddrErr_out 1-cycle pulse; fetch at 0x2000.
//  PC=0xFFFFFFFC fetched -> next addr 0x0.
//  Reset asserted mid-REQ -> all outputs at reset values next edge; refetch from RESET_PC.

Source files
------------

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - PC holder and instruction fetch stage with redirect and 1-entry output buffer
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk_in,
    input  logic        Reset_n_in,
    input  logic        ExValid_in,
    input  logic        Branch_in,
    input  logic        Jump_in,
    input  logic [31:0] JumpTarget_in,
    input  logic [31:0] BranchPc_in,
    input  logic [31:0] BranchOffset_in,
    output logic        ImemReq_out,
    output logic [31:0] ImemAddr_out,
    input  logic        ImemAck_in,
    input  logic [31:0] ImemData_in,
    output logic [31:0] Instr_out,
    output logic [31:0] InstrPc_out,
    output logic        InstrValid_out,
    input  logic        InstrReady_in,
    output logic        AddrErr_out
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        discard_q, discard_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        redirect;
    logic [31:0] branch_target;
    logic [31:0] raw_target;
    logic [31:0] target;

    assign redirect      = ExValid_in & (Branch_in | Jump_in);
    assign branch_target = BranchPc_in + 32'd4 + (BranchOffset_in << 2);
    assign raw_target    = Jump_in ? JumpTarget_in : branch_target;
    assign target        = {raw_target[31:2], 2'b00};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        discard_d  = discard_q;
        req_d      = req_q;
        addr_d     = addr_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = redirect & (raw_target[1:0] != 2'b00);

        case (state_q)
            IDLE: begin
                state_d = REQ;
                req_d   = 1'b1;
                addr_d  = redirect ? target : pc_q;
                if (redirect) begin
                    pc_d = target;
                end
            end
            REQ: begin
                if (ImemAck_in) begin
                    // A redirect or a pending discard both throw away this word and refetch.
                    if (redirect) begin
                        pc_d      = target;
                        addr_d    = target;
                        discard_d = 1'b0;
                    end else if (discard_q) begin
                        addr_d    = pc_q;
                        discard_d = 1'b0;
                    end else begin
                        instr_d    = ImemData_in;
                        instr_pc_d = addr_q;
                        valid_d    = 1'b1;
                        pc_d       = addr_q + 32'd4;
                        req_d      = 1'b0;
                        state_d    = HOLD;
                    end
                end else if (redirect) begin
                    pc_d      = target;
                    discard_d = 1'b1;
                end
            end
            HOLD: begin
                if (redirect) begin
                    pc_d    = target;
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = target;
                    state_d = REQ;
                end else if (InstrReady_in) begin
                    valid_d = 1'b0;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_in) begin
        if (!Reset_n_in) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            discard_q  <= 1'b0;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            discard_q  <= discard_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    assign ImemReq_out    = req_q;
    assign ImemAddr_out   = addr_q;
    assign Instr_out      = instr_q;
    assign InstrPc_out    = instr_pc_q;
    assign InstrValid_out = valid_q;
    assign AddrErr_out    = err_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - randomized self-checking bench for pc_fetch_unit against a fetch-stream model
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid, branch, jump;
    logic [31:0] jump_tgt, br_pc, br_off;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr, instr_pc;
    logic        instr_valid, instr_ready, addr_err;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .Clk_in         (clk),
        .Reset_n_in     (rst_n),
        .ExValid_in     (ex_valid),
        .Branch_in      (branch),
        .Jump_in        (jump),
        .JumpTarget_in  (jump_tgt),
        .BranchPc_in    (br_pc),
        .BranchOffset_in(br_off),
        .ImemReq_out    (imem_req),
        .ImemAddr_out   (imem_addr),
        .ImemAck_in     (imem_ack),
        .ImemData_in    (imem_data),
        .Instr_out      (instr),
        .InstrPc_out    (instr_pc),
        .InstrValid_out (instr_valid),
        .InstrReady_in  (instr_ready),
        .AddrErr_out    (addr_err)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    // Model: exp_pc is the PC of the next instruction decode should receive.
    logic [31:0] exp_pc;
    logic        exp_err;
    logic        was_rst;
    logic        mem_busy;
    int          mem_wait;
    int          mem_lat;
    logic [31:0] mem_addr;
    int          gap;
    int          xfer_cnt;
    logic [31:0] last_xfer_pc;
    logic        saw_40;
    logic [31:0] held_instr, held_pc;
    logic        found;

    task automatic step(input logic rst, input logic rdy, input logic exv, input logic br,
                        input logic jp, input logic [31:0] jt, input logic [31:0] bpc,
                        input logic [31:0] boff);
        logic [31:0] raw;
        logic        redir;
        @(negedge clk);
        if (was_rst) begin
            check_eq("rst_req", imem_req, 0);
            check_eq("rst_addr", imem_addr, RST_PC);
            check_eq("rst_valid", instr_valid, 0);
            check_eq("rst_instr", instr, 0);
            check_eq("rst_instr_pc", instr_pc, 0);
            check_eq("rst_err", addr_err, 0);
        end else begin
            check_eq("addr_err", addr_err, exp_err);
            check_eq("req_in_hold", imem_req & instr_valid, 0);
        end
        if (instr_valid && instr_pc == 32'h40) saw_40 = 1'b1;
        rst_n       = ~rst;
        instr_ready = rdy;
        ex_valid    = exv;
        branch      = br;
        jump        = jp;
        jump_tgt    = jt;
        br_pc       = bpc;
        br_off      = boff;
        imem_ack    = 1'b0;
        imem_data   = $urandom;
        was_rst     = rst;
        if (rst) begin
            exp_pc   = RST_PC;
            exp_err  = 1'b0;
            mem_busy = 1'b0;
            gap      = 0;
        end else begin
            if (imem_req) begin
                if (!mem_busy) begin
                    mem_busy = 1'b1;
                    mem_addr = imem_addr;
                    mem_wait = (mem_lat < 0) ? int'($urandom_range(0, 3)) : mem_lat;
                end else begin
                    check_eq("addr_stable", imem_addr, mem_addr);
                end
                if (mem_wait == 0) begin
                    imem_ack  = 1'b1;
                    imem_data = mem_word(imem_addr);
                    mem_busy  = 1'b0;
                end else begin
                    mem_wait--;
                end
            end
            if (instr_valid && rdy) begin
                check_eq("instr_pc", instr_pc, exp_pc);
                check_eq("instr", instr, mem_word(exp_pc));
                last_xfer_pc = instr_pc;
                exp_pc       = exp_pc + 32'd4;
                xfer_cnt++;
                gap = 0;
            end else begin
                gap++;
                if (gap > 100) begin
                    check_eq("stall", gap, 0);
                    gap = 0;
                end
            end
            redir = exv & (br | jp);
            raw   = jp ? jt : bpc + 32'd4 + (boff << 2);
            if (redir) exp_pc = {raw[31:2], 2'b00};
            exp_err = redir & (raw[1:0] != 2'b00);
        end
    endtask

    task automatic idle_step(input logic rst, input logic rdy);
        step(rst, rdy, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0);
    endtask

    task automatic redir_step(input logic rdy, input logic br, input logic jp,
                              input logic [31:0] jt, input logic [31:0] bpc, input logic [31:0] boff);
        step(1'b0, rdy, 1'b1, br, jp, jt, bpc, boff);
    endtask

    task automatic post_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; instr_ready = 1'b0; ex_valid = 1'b0; branch = 1'b0; jump = 1'b0;
        jump_tgt = '0; br_pc = '0; br_off = '0; imem_ack = 1'b0; imem_data = '0;
        exp_pc = RST_PC; exp_err = 1'b0; mem_busy = 1'b0; mem_wait = 0; mem_lat = 0;
        mem_addr = '0; gap = 0; xfer_cnt = 0; last_xfer_pc = '0; saw_40 = 1'b0; found = 1'b0;
        repeat (2) @(posedge clk);
        was_rst = 1'b1;

        // Zero-wait memory, decode always ready: 0,4,8 in seven cycles.
        for (int i = 0; i < 7; i++) idle_step(1'b0, 1'b1);
        check_eq("seq_count", xfer_cnt, 3);
        check_eq("seq_last_pc", last_xfer_pc, 32'h8);

        // Decode stalls in HOLD.
        idle_step(1'b0, 1'b0);
        post_edge();
        held_instr = instr;
        held_pc    = instr_pc;
        check_eq("hold_pc", held_pc, 32'hC);
        for (int i = 0; i < 5; i++) begin
            idle_step(1'b0, 1'b0);
            check_eq("hold_instr", instr, held_instr);
            check_eq("hold_instr_pc", instr_pc, held_pc);
            check_eq("hold_no_req", imem_req, 0);
            check_eq("hold_valid", instr_valid, 1);
        end
        idle_step(1'b0, 1'b1);
        post_edge();
        check_eq("resume_addr", imem_addr, 32'h10);
        check_eq("resume_req", imem_req, 1);

        // Backward branch from HOLD.
        idle_step(1'b0, 1'b0);
        redir_step(1'b0, 1'b1, 1'b0, 32'd0, 32'h100, 32'hFFFF_FFFE);
        post_edge();
        check_eq("branch_addr", imem_addr, 32'hFC);
        check_eq("branch_req", imem_req, 1);
        check_eq("branch_valid", instr_valid, 0);

        // Jump during a slow read at 0x40: the 0x40 word must never reach decode.
        redir_step(1'b1, 1'b0, 1'b1, 32'h40, 32'd0, 32'd0);
        mem_lat = 3;
        saw_40  = 1'b0;
        idle_step(1'b0, 1'b1);
        redir_step(1'b1, 1'b0, 1'b1, 32'h2000, 32'd0, 32'd0);
        found = 1'b0;
        for (int i = 0; i < 12; i++) begin
            idle_step(1'b0, 1'b1);
            if (imem_req && imem_addr == 32'h2000) begin
                found = 1'b1;
                break;
            end
        end
        check_eq("jump_refetch", found, 1);
        check_eq("no_valid_40", saw_40, 0);

        // Misaligned jump while the handshake also completes.
        mem_lat = 0;
        repeat (8) idle_step(1'b0, 1'b0);
        post_edge();
        check_eq("pre_err_valid", instr_valid, 1);
        check_eq("pre_err_pc", instr_pc, 32'h2000);
        redir_step(1'b1, 1'b0, 1'b1, 32'h2002, 32'd0, 32'd0);
        post_edge();
        check_eq("err_pulse", addr_err, 1);
        check_eq("err_addr", imem_addr, 32'h2000);
        check_eq("err_req", imem_req, 1);
        check_eq("err_valid", instr_valid, 0);
        idle_step(1'b0, 1'b1);
        post_edge();
        check_eq("err_clear", addr_err, 0);

        // Sequential wrap at the top of the address space.
        redir_step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0, 32'd0);
        idle_step(1'b0, 1'b1);
        idle_step(1'b0, 1'b1);
        post_edge();
        check_eq("wrap_addr", imem_addr, 32'h0);
        check_eq("wrap_req", imem_req, 1);
        check_eq("wrap_last_pc", last_xfer_pc, 32'hFFFF_FFFC);

        // Reset while a read is outstanding.
        redir_step(1'b1, 1'b0, 1'b1, 32'h80, 32'd0, 32'd0);
        mem_lat = 3;
        idle_step(1'b0, 1'b1);
        idle_step(1'b1, 1'b0);
        post_edge();
        check_eq("mid_rst_req", imem_req, 0);
        check_eq("mid_rst_addr", imem_addr, RST_PC);
        check_eq("mid_rst_valid", instr_valid, 0);
        idle_step(1'b0, 1'b1);
        post_edge();
        check_eq("refetch_req", imem_req, 1);
        check_eq("refetch_addr", imem_addr, RST_PC);

        // Random traffic: variable latency, decode stalls, branches/jumps, occasional reset.
        mem_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_rdy, r_exv, r_br, r_jp;
            logic [31:0] r_jt, r_bpc, r_boff;
            r_rst  = ($urandom_range(0, 499) == 0);
            r_rdy  = ($urandom_range(0, 3) != 0);
            r_exv  = ($urandom_range(0, 7) == 0);
            r_br   = $urandom_range(0, 1);
            r_jp   = $urandom_range(0, 1);
            r_jt   = $urandom_range(0, 65535);
            r_bpc  = $urandom_range(0, 65535) & 32'hFFFF_FFFC;
            r_boff = {{16{r_jt[3]}}, 8'h0, $urandom_range(0, 255)} ;
            step(r_rst, r_rdy, r_exv, r_br, r_jp, r_jt, r_bpc, r_boff);
        end
        repeat (4) idle_step(1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
